// File: rtl/updown_button_ctrl.sv
// updown_button_ctrl
// Turns two raw push-buttons into single-cycle step requests for an up/down
// counter. Each button is synchronised and debounced. A press gives one pulse.
// Holding the button gives auto-repeat pulses: the first after HOLD_CYCLES
// edges, then one every REPEAT_CYCLES edges. Pressing both buttons together
// gives no pulses until both are released.

module updown_button_ctrl #(
   parameter int DB_CYCLES     = 16,
   parameter int HOLD_CYCLES   = 64,
   parameter int REPEAT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_up,
   input  logic btn_down,
   output logic enable,
   output logic direction,
   output logic up_lvl,
   output logic down_lvl
);

   localparam int DBW  = $clog2(DB_CYCLES + 1);
   localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int TW   = $clog2(TMAX);

   localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
   localparam logic [DBW-1:0] DB_ONE    = DBW'(1);
   localparam logic [TW-1:0]  HOLD_LOAD = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0]  REP_LOAD  = TW'(REPEAT_CYCLES - 1);
   localparam logic [TW-1:0]  T_ONE     = TW'(1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_HOLD   = 2'd1;
   localparam logic [1:0] S_REPEAT = 2'd2;
   localparam logic [1:0] S_LOCK   = 2'd3;

   // Bit 0 of each pair is the up button and bit 1 is the down button.
   logic [1:0]     r_sync1;
   logic [1:0]     r_sync2;
   logic [DBW-1:0] r_dbCnt [2];
   logic [1:0]     r_lvl;
   logic [1:0]     r_lvlPrev;
   logic [1:0]     r_state;
   logic [TW-1:0]  r_timer;
   logic           r_enable;
   logic           r_dir;

   logic           w_upRise;
   logic           w_downRise;
   logic           w_actLvl;
   logic           w_oppRise;
   logic [1:0]     w_stateNext;
   logic [TW-1:0]  w_timerNext;
   logic           w_pulse;
   logic           w_dirNext;

   // Two-flop synchroniser; these are the only flops that see the raw buttons.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 2'b00;
         r_sync2 <= 2'b00;
      end else begin
         r_sync1 <= {btn_down, btn_up};
         r_sync2 <= r_sync1;
      end
   end

   // Debounce: the level flips only after DB_CYCLES disagreeing samples in a row.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lvl <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            r_dbCnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (r_sync2[i] != r_lvl[i]) begin
               if (r_dbCnt[i] == DB_LAST) begin
                  r_lvl[i]   <= ~r_lvl[i];
                  r_dbCnt[i] <= '0;
               end else begin
                  r_dbCnt[i] <= r_dbCnt[i] + DB_ONE;
               end
            end else begin
               r_dbCnt[i] <= '0;
            end
         end
      end
   end

   assign w_upRise   = r_lvl[0] & ~r_lvlPrev[0];
   assign w_downRise = r_lvl[1] & ~r_lvlPrev[1];
   // While a button is active, r_dir records which button it is.
   assign w_actLvl   = r_dir ? r_lvl[0] : r_lvl[1];
   assign w_oppRise  = r_dir ? w_downRise : w_upRise;

   // Next-state logic. A rise on the opposite button has priority over a release.
   always_comb begin
      w_stateNext = r_state;
      w_timerNext = r_timer;
      w_pulse     = 1'b0;
      w_dirNext   = r_dir;
      case (r_state)
         S_IDLE: begin
            if (r_lvl[0] && r_lvl[1]) begin
               w_stateNext = S_LOCK;
            end else if (w_upRise) begin
               w_pulse     = 1'b1;
               w_dirNext   = 1'b1;
               w_timerNext = HOLD_LOAD;
               w_stateNext = S_HOLD;
            end else if (w_downRise) begin
               w_pulse     = 1'b1;
               w_dirNext   = 1'b0;
               w_timerNext = HOLD_LOAD;
               w_stateNext = S_HOLD;
            end
         end
         S_HOLD, S_REPEAT: begin
            if (w_oppRise) begin
               w_stateNext = S_LOCK;
            end else if (!w_actLvl) begin
               w_stateNext = S_IDLE;
            end else if (r_timer == '0) begin
               w_pulse     = 1'b1;
               w_timerNext = REP_LOAD;
               w_stateNext = S_REPEAT;
            end else begin
               w_timerNext = r_timer - T_ONE;
            end
         end
         S_LOCK: begin
            if (!r_lvl[0] && !r_lvl[1]) begin
               w_stateNext = S_IDLE;
            end
         end
         default: begin
            w_stateNext = S_IDLE;
         end
      endcase
   end

   // Register the FSM state, the timer and the registered pulse outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_timer   <= '0;
         r_enable  <= 1'b0;
         r_dir     <= 1'b1;
         r_lvlPrev <= 2'b00;
      end else begin
         r_state   <= w_stateNext;
         r_timer   <= w_timerNext;
         r_enable  <= w_pulse;
         r_dir     <= w_dirNext;
         r_lvlPrev <= r_lvl;
      end
   end

   assign enable    = r_enable;
   assign direction = r_dir;
   assign up_lvl    = r_lvl[0];
   assign down_lvl  = r_lvl[1];

endmodule

// File: tb/tb_updown_button_ctrl.sv
// tb_updown_button_ctrl
// Each test task drives button patterns one edge at a time. After every edge it
// compares the DUT outputs with a reference model. The model describes
// debouncing as a window rule: the last DB samples since the previous flip all
// disagree with the level. It describes pulses as a schedule of absolute edge
// numbers. Directed tasks also compare pulse timing with fixed expected edges.

module tb_updown_button_ctrl;

   localparam int DB  = 4;
   localparam int HLD = 10;
   localparam int REP = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_up = 1'b0;
   logic btn_down = 1'b0;
   logic enable, direction, up_lvl, down_lvl;

   int total = 0;
   int bad = 0;

   // Reference model state. Index 0 is up and index 1 is down.
   // mT is the edge number since reset release.
   int       mT;
   logic     mEn, mDir;
   logic [1:0] mLvl, mPrev;
   int       mMode;
   int       mNext;
   int       mLastTog [2];
   bit       rawHist [2][4096];

   updown_button_ctrl #(
      .DB_CYCLES(DB), .HOLD_CYCLES(HLD), .REPEAT_CYCLES(REP)
   ) dut (
      .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
      .enable(enable), .direction(direction), .up_lvl(up_lvl), .down_lvl(down_lvl)
   );

   always #5 clk = ~clk;

   function automatic void modelReset();
      mT = 0; mEn = 1'b0; mDir = 1'b1; mLvl = 2'b00; mPrev = 2'b00;
      mMode = 0; mNext = 0; mLastTog[0] = 0; mLastTog[1] = 0;
   endfunction

   // Synchronised sample used by the debouncer at edge e. It is the raw value from edge e-2.
   function automatic bit synced(input int b, input int e);
      if (e >= 3) return rawHist[b][e-2];
      return 1'b0;
   endfunction

   function automatic void modelStep(input bit u, input bit d);
      logic [1:0] newLvl;
      bit upRise, dnRise, actLvl, oppRise, allDiff;
      mT++;
      rawHist[0][mT] = u;
      rawHist[1][mT] = d;
      upRise = mLvl[0] && !mPrev[0];
      dnRise = mLvl[1] && !mPrev[1];
      mEn = 1'b0;
      if (mMode == 0) begin
         if (mLvl[0] && mLvl[1]) mMode = 2;
         else if (upRise) begin mEn = 1; mDir = 1; mMode = 1; mNext = mT + HLD; end
         else if (dnRise) begin mEn = 1; mDir = 0; mMode = 1; mNext = mT + HLD; end
      end else if (mMode == 1) begin
         actLvl  = mDir ? mLvl[0] : mLvl[1];
         oppRise = mDir ? dnRise : upRise;
         if (oppRise) mMode = 2;
         else if (!actLvl) mMode = 0;
         else if (mT == mNext) begin mEn = 1; mNext = mT + REP; end
      end else begin
         if (!mLvl[0] && !mLvl[1]) mMode = 0;
      end
      newLvl = mLvl;
      for (int b = 0; b < 2; b++) begin
         if (mT - mLastTog[b] >= DB) begin
            allDiff = 1;
            for (int k = 0; k < DB; k++)
               if (synced(b, mT - k) == mLvl[b]) allDiff = 0;
            if (allDiff) begin
               newLvl[b] = ~mLvl[b];
               mLastTog[b] = mT;
            end
         end
      end
      mPrev = mLvl;
      mLvl  = newLvl;
   endfunction

   // Advances the DUT and the model by one edge. Outputs are sampled on the falling edge.
   task automatic tick(input bit u, input bit d, input bit r);
      btn_up = u; btn_down = d; rst = r;
      @(posedge clk);
      if (r) modelReset(); else modelStep(u, d);
      @(negedge clk);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         tick(1, 1, 1);
         total++;
         if ({enable, direction, up_lvl, down_lvl} !== 4'b0100) begin
            bad++;
            $display("FAIL reset edge=%0d got=%b want=0100", i, {enable, direction, up_lvl, down_lvl});
         end
      end
      for (int i = 0; i < 4; i++) begin
         tick(0, 0, 0);
         total++;
         if ({enable, direction, up_lvl, down_lvl} !== {mEn, mDir, mLvl[0], mLvl[1]}) begin
            bad++;
            $display("FAIL reset_idle edge=%0d got=%b want=%b", mT, {enable, direction, up_lvl, down_lvl}, {mEn, mDir, mLvl[0], mLvl[1]});
         end
      end
   endtask

   task automatic test_single_press();
      int first, cnt;
      first = -1; cnt = 0;
      tick(0, 0, 1);
      for (int e = 1; e <= 28; e++) begin
         tick(e <= 8, 0, 0);
         total++;
         if ({enable, direction, up_lvl, down_lvl} !== {mEn, mDir, mLvl[0], mLvl[1]}) begin
            bad++;
            $display("FAIL single edge=%0d got=%b want=%b", mT, {enable, direction, up_lvl, down_lvl}, {mEn, mDir, mLvl[0], mLvl[1]});
         end
         if (enable === 1'b1) begin
            cnt++;
            if (first < 0) first = e;
         end
      end
      total++;
      if (first != DB + 3 || cnt != 1) begin
         bad++;
         $display("FAIL single_timing got first=%0d count=%0d want first=%0d count=1", first, cnt, DB + 3);
      end
   endtask

   task automatic test_bounce();
      int cnt;
      logic pulseDir;
      cnt = 0; pulseDir = 1'bx;
      tick(0, 0, 1);
      for (int e = 1; e <= 40; e++) begin
         tick(0, (e <= 10) ? (((e - 1) / 2) % 2 == 0) : (e <= 18), 0);
         total++;
         if ({enable, direction, up_lvl, down_lvl} !== {mEn, mDir, mLvl[0], mLvl[1]}) begin
            bad++;
            $display("FAIL bounce edge=%0d got=%b want=%b", mT, {enable, direction, up_lvl, down_lvl}, {mEn, mDir, mLvl[0], mLvl[1]});
         end
         if (enable === 1'b1) begin
            cnt++;
            pulseDir = direction;
         end
      end
      total++;
      if (cnt != 1 || pulseDir !== 1'b0) begin
         bad++;
         $display("FAIL bounce_pulse got count=%0d dir=%b want count=1 dir=0", cnt, pulseDir);
      end
   endtask

   task automatic test_auto_repeat();
      int got [$];
      int want [$];
      want = '{7, 17, 20, 23, 26, 29};
      tick(0, 0, 1);
      for (int e = 1; e <= 45; e++) begin
         tick(e <= 29, 0, 0);
         total++;
         if ({enable, direction, up_lvl, down_lvl} !== {mEn, mDir, mLvl[0], mLvl[1]}) begin
            bad++;
            $display("FAIL repeat edge=%0d got=%b want=%b", mT, {enable, direction, up_lvl, down_lvl}, {mEn, mDir, mLvl[0], mLvl[1]});
         end
         if (enable === 1'b1 && e <= 29) begin
            got.push_back(e);
            total++;
            if (direction !== 1'b1) begin
               bad++;
               $display("FAIL repeat_dir edge=%0d got=%b want=1", e, direction);
            end
         end
      end
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL repeat_edges got=%p want=%p", got, want);
      end
   endtask

   task automatic test_lock();
      int cntA, cntB;
      logic dirB;
      cntA = 0; cntB = 0; dirB = 1'bx;
      tick(0, 0, 1);
      for (int e = 1; e <= 70; e++) begin
         if (e <= 30) tick(1, e >= 10, 0);
         else if (e <= 45) tick(0, 0, 0);
         else tick(0, e <= 55, 0);
         total++;
         if ({enable, direction, up_lvl, down_lvl} !== {mEn, mDir, mLvl[0], mLvl[1]}) begin
            bad++;
            $display("FAIL lock edge=%0d got=%b want=%b", mT, {enable, direction, up_lvl, down_lvl}, {mEn, mDir, mLvl[0], mLvl[1]});
         end
         if (enable === 1'b1) begin
            if (e <= 45) cntA++;
            else begin cntB++; dirB = direction; end
         end
      end
      total++;
      if (cntA != 1 || cntB != 1 || dirB !== 1'b0) begin
         bad++;
         $display("FAIL lock_pulses got a=%0d b=%0d dir=%b want a=1 b=1 dir=0", cntA, cntB, dirB);
      end
   endtask

   task automatic test_reset_mid();
      int first;
      first = -1;
      tick(0, 0, 1);
      for (int e = 1; e <= 14; e++) tick(1, 0, 0);
      tick(1, 0, 1);
      total++;
      if ({enable, direction, up_lvl, down_lvl} !== 4'b0100) begin
         bad++;
         $display("FAIL reset_mid got=%b want=0100", {enable, direction, up_lvl, down_lvl});
      end
      for (int e = 1; e <= 12; e++) begin
         tick(1, 0, 0);
         total++;
         if ({enable, direction, up_lvl, down_lvl} !== {mEn, mDir, mLvl[0], mLvl[1]}) begin
            bad++;
            $display("FAIL reset_mid edge=%0d got=%b want=%b", mT, {enable, direction, up_lvl, down_lvl}, {mEn, mDir, mLvl[0], mLvl[1]});
         end
         if (enable === 1'b1 && first < 0) first = e;
      end
      total++;
      if (first != DB + 3) begin
         bad++;
         $display("FAIL reset_mid_first got=%0d want=%0d", first, DB + 3);
      end
   endtask

   task automatic test_random();
      bit u, d;
      for (int s = 0; s < 4; s++) begin
         u = 0; d = 0;
         tick(0, 0, 1);
         for (int e = 1; e <= 500; e++) begin
            if ($urandom_range(0, 13) == 0) u = ~u;
            if ($urandom_range(0, 13) == 0) d = ~d;
            tick(u, d, 0);
            total++;
            if ({enable, direction, up_lvl, down_lvl} !== {mEn, mDir, mLvl[0], mLvl[1]}) begin
               bad++;
               $display("FAIL random seg=%0d edge=%0d got=%b want=%b", s, mT, {enable, direction, up_lvl, down_lvl}, {mEn, mDir, mLvl[0], mLvl[1]});
            end
         end
      end
   endtask

   // Runs every scenario in sequence and prints the summary line.
   initial begin
      modelReset();
      @(negedge clk);
      test_reset();
      test_single_press();
      test_bounce();
      test_auto_repeat();
      test_lock();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
